// File: rtl/midi_pkg.sv
// Shared constants, message record and parser state type for the MIDI message parser.
package midi_pkg;

    localparam logic [3:0] CMD_NOTE_OFF = 4'h8;
    localparam logic [3:0] CMD_NOTE_ON  = 4'h9;
    localparam logic [3:0] CMD_POLY_AT  = 4'hA;
    localparam logic [3:0] CMD_CTRL     = 4'hB;
    localparam logic [3:0] CMD_PROGRAM  = 4'hC;
    localparam logic [3:0] CMD_CHAN_AT  = 4'hD;
    localparam logic [3:0] CMD_PITCH    = 4'hE;

    localparam logic [7:0] SYS_SYSEX    = 8'hF0;
    localparam logic [7:0] SYS_MTC      = 8'hF1;
    localparam logic [7:0] SYS_SONG_POS = 8'hF2;
    localparam logic [7:0] SYS_SONG_SEL = 8'hF3;
    localparam logic [7:0] SYS_EOX      = 8'hF7;
    localparam logic [7:0] RT_MIN       = 8'hF8;
    localparam logic [7:0] RT_SENSE     = 8'hFE;

    localparam logic [6:0] NOTE_OFF_VEL = 7'h40;

    typedef struct packed {
        logic [7:0] status;
        logic [6:0] d1;
        logic [6:0] d2;
    } midi_msg_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA1,
        ST_DATA2,
        ST_SKIP,
        ST_SYSEX
    } parser_state_t;

    function automatic logic [1:0] data_len(input logic [3:0] cmd);
        case (cmd)
            CMD_PROGRAM, CMD_CHAN_AT: return 2'd1;
            CMD_NOTE_OFF, CMD_NOTE_ON, CMD_POLY_AT, CMD_CTRL, CMD_PITCH: return 2'd2;
            default: return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/midi_msg_fifo.sv
// Small synchronous message FIFO; the head entry is read straight from the storage registers.
module midi_msg_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 22
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic         do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty   = (wr_q == rd_q);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = push_data;
            wr_d = wr_q + {{AW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_d = rd_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

endmodule

// File: rtl/midi_msg_parser.sv
// Parses a raw MIDI byte stream into complete channel messages queued in a message FIFO.
// Build option MIDI_ACTIVE_SENSE_EN adds the active-sense timeout that emits a synthetic all-off {FE,00,00}.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int CLK_HZ   = 24_000_000,
    parameter int SENSE_MS = 300
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_status,
    output logic [6:0] out_data1,
    output logic [6:0] out_data2,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       sysex_busy
);
    parser_state_t state_q, state_d;
    logic [7:0]    rs_q, rs_d;
    logic [6:0]    d1_q, d1_d;
    logic [1:0]    skip_q, skip_d;
    logic          rdy_en_q;
    logic          accept, emit, push, full, empty;
    midi_msg_t     emit_msg, push_msg, head;

    assign accept     = in_valid && in_ready;
    assign sysex_busy = (state_q == ST_SYSEX);

    // rs_q == 0 means "no running status"; any valid channel status has bit 7 set.
    always_comb begin
        state_d  = state_q;
        rs_d     = rs_q;
        d1_d     = d1_q;
        skip_d   = skip_q;
        emit     = 1'b0;
        emit_msg = '0;
        if (accept && in_data < RT_MIN) begin
            if (in_data[7]) begin
                if (in_data < SYS_SYSEX) begin
                    rs_d    = in_data;
                    state_d = ST_DATA1;
                end else begin
                    case (in_data)
                        SYS_SYSEX: begin
                            rs_d    = '0;
                            state_d = ST_SYSEX;
                        end
                        SYS_MTC, SYS_SONG_SEL: begin
                            rs_d    = '0;
                            skip_d  = 2'd1;
                            state_d = ST_SKIP;
                        end
                        SYS_SONG_POS: begin
                            skip_d  = 2'd2;
                            state_d = ST_SKIP;
                        end
                        default: begin
                            rs_d    = '0;
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end else begin
                case (state_q)
                    ST_IDLE, ST_DATA1: begin
                        if (state_q == ST_DATA1 || rs_q[7]) begin
                            d1_d = in_data[6:0];
                            if (data_len(rs_q[7:4]) == 2'd1) begin
                                emit            = 1'b1;
                                emit_msg.status = rs_q;
                                emit_msg.d1     = in_data[6:0];
                                state_d         = ST_IDLE;
                            end else begin
                                state_d = ST_DATA2;
                            end
                        end
                    end
                    ST_DATA2: begin
                        emit            = 1'b1;
                        emit_msg.status = rs_q;
                        emit_msg.d1     = d1_q;
                        emit_msg.d2     = in_data[6:0];
                        state_d         = ST_IDLE;
                    end
                    ST_SKIP: begin
                        skip_d = skip_q - 2'd1;
                        if (skip_q <= 2'd1) state_d = ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
        if (emit && rs_q[7:4] == CMD_NOTE_ON && emit_msg.d2 == 7'd0) begin
            emit_msg.status = {CMD_NOTE_OFF, rs_q[3:0]};
            emit_msg.d2     = NOTE_OFF_VEL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rs_q     <= '0;
            d1_q     <= '0;
            skip_q   <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rs_q     <= rs_d;
            d1_q     <= d1_d;
            skip_q   <= skip_d;
            rdy_en_q <= 1'b1;
        end
    end

`ifdef MIDI_ACTIVE_SENSE_EN
    localparam int        SENSE_TICKS = CLK_HZ / 1000 * SENSE_MS;
    localparam int        TW          = $clog2(SENSE_TICKS + 1);
    localparam midi_msg_t SENSE_MSG   = '{status: RT_SENSE, d1: 7'd0, d2: 7'd0};

    logic          armed_q, armed_d, pend_q, pend_d, syn_push;
    logic [TW-1:0] tmr_q, tmr_d;

    // A pending synthetic message blocks input, so it never collides with a parser push.
    always_comb begin
        armed_d  = armed_q;
        pend_d   = pend_q;
        tmr_d    = tmr_q;
        syn_push = 1'b0;
        if (pend_q && !full) begin
            syn_push = 1'b1;
            pend_d   = 1'b0;
        end
        if (accept && (armed_q || in_data == RT_SENSE)) begin
            armed_d = 1'b1;
            tmr_d   = '0;
        end else if (armed_q) begin
            if (tmr_q == TW'(SENSE_TICKS - 1)) begin
                armed_d = 1'b0;
                pend_d  = 1'b1;
                tmr_d   = '0;
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_q <= 1'b0;
            pend_q  <= 1'b0;
            tmr_q   <= '0;
        end else begin
            armed_q <= armed_d;
            pend_q  <= pend_d;
            tmr_q   <= tmr_d;
        end
    end

    assign in_ready = rdy_en_q && !full && !pend_q;
    assign push     = syn_push || emit;
    assign push_msg = syn_push ? SENSE_MSG : emit_msg;
`else
    assign in_ready = rdy_en_q && !full;
    assign push     = emit;
    assign push_msg = emit_msg;

    // Timer parameters only shape hardware in the active-sense build.
    if (CLK_HZ / 1000 * SENSE_MS < 1) begin : g_sense_cfg_unused
    end
`endif

    midi_msg_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(midi_msg_t))
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_msg),
        .pop       (out_ready && !empty),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign out_valid  = !empty;
    assign out_status = head.status;
    assign out_data1  = head.d1;
    assign out_data2  = head.d2;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Self-checking bench for midi_msg_parser: directed MIDI scenarios plus randomized byte streams against a reference model.
module tb_midi_msg_parser;
    localparam int CLK_HZ_TB   = 1000;
    localparam int SENSE_MS_TB = 40;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_status;
    logic [6:0] out_data1;
    logic [6:0] out_data2;
    logic       out_valid;
    logic       out_ready;
    logic       sysex_busy;

    int errors = 0;
    int checks = 0;

    logic [21:0] exp_q[$];
    logic [21:0] got_q[$];

    int         m_rs;
    logic [6:0] m_buf[$];
    int         m_skip;
    bit         m_sysex;

    always #5 clk = ~clk;

    midi_msg_parser #(
        .DEPTH    (4),
        .CLK_HZ   (CLK_HZ_TB),
        .SENSE_MS (SENSE_MS_TB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_status (out_status),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sysex_busy (sysex_busy)
    );

    // Record every message handed to the consumer; pop happens on the following rising edge.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid && out_ready)
            got_q.push_back({out_status, out_data1, out_data2});
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic void model_reset();
        m_rs    = -1;
        m_skip  = 0;
        m_sysex = 0;
        m_buf.delete();
        exp_q.delete();
        got_q.delete();
    endfunction

    function automatic void clear_logs();
        exp_q.delete();
        got_q.delete();
    endfunction

    // Reference model: MIDI rules applied to each accepted byte.
    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] st;
        logic [6:0] d2;
        int         len;
        if (b >= 8'hF8) return;
        if (b[7]) begin
            m_buf.delete();
            m_sysex = 0;
            m_skip  = 0;
            if (b < 8'hF0) m_rs = int'(b);
            else if (b == 8'hF0) begin m_rs = -1; m_sysex = 1; end
            else if (b == 8'hF1 || b == 8'hF3) begin m_rs = -1; m_skip = 1; end
            else if (b == 8'hF2) m_skip = 2;
            else m_rs = -1;
            return;
        end
        if (m_sysex) return;
        if (m_skip > 0) begin m_skip--; return; end
        if (m_rs < 0) return;
        m_buf.push_back(b[6:0]);
        st  = m_rs[7:0];
        len = (st[7:4] == 4'hC || st[7:4] == 4'hD) ? 1 : 2;
        if (m_buf.size() < len) return;
        d2 = (len == 2) ? m_buf[1] : 7'd0;
        if (st[7:4] == 4'h9 && len == 2 && d2 == 7'd0) begin
            st = {4'h8, st[3:0]};
            d2 = 7'h40;
        end
        exp_q.push_back({st, m_buf[0], d2});
        m_buf.delete();
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte=%h in_ready=%b required=1", b, in_ready);
        end else begin
            model_byte(b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks += 6;
        if (in_ready !== 1'b0)   begin errors++; $display("FAIL reset_in_ready got=%b required=0", in_ready); end
        if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
        if (out_status !== 8'h0) begin errors++; $display("FAIL reset_out_status got=%h required=00", out_status); end
        if (out_data1 !== 7'h0)  begin errors++; $display("FAIL reset_out_data1 got=%h required=00", out_data1); end
        if (out_data2 !== 7'h0)  begin errors++; $display("FAIL reset_out_data2 got=%h required=00", out_data2); end
        if (sysex_busy !== 1'b0) begin errors++; $display("FAIL reset_sysex_busy got=%b required=0", sysex_busy); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_early got=%b required=0", in_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b required=1", in_ready); end
    endtask

    task automatic test_single();
        clear_logs();
        out_ready = 1'b1;
        send_byte(8'h90);
        send_byte(8'h3C);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early got=%b required=0", out_valid); end
        send_byte(8'h64);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency got=%b required=1", out_valid); end
        wait_cycles(5);
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            errors++; $display("FAIL single_count got=%0d required=%0d", got_q.size(), 1);
        end else begin
            checks += 2;
            if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL single_msg got=%h required=%h", got_q[0], exp_q[0]); end
            if (got_q[0] !== {8'h90, 7'h3C, 7'h64}) begin errors++; $display("FAIL single_const got=%h required=%h", got_q[0], {8'h90, 7'h3C, 7'h64}); end
        end
    endtask

    task automatic test_running_status();
        logic [7:0] seq[7] = '{8'h90, 8'h3C, 8'h64, 8'h40, 8'h7F, 8'h3C, 8'h00};
        clear_logs();
        out_ready = 1'b1;
        foreach (seq[i]) send_byte(seq[i]);
        wait_cycles(6);
        checks++;
        if (got_q.size() != 3 || exp_q.size() != 3) begin
            errors++; $display("FAIL running_count got=%0d required=3", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL running_msg%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() == 3) begin
            checks++;
            if (got_q[2] !== {8'h80, 7'h3C, 7'h40}) begin errors++; $display("FAIL vel0_rewrite got=%h required=%h", got_q[2], {8'h80, 7'h3C, 7'h40}); end
        end
    endtask

    task automatic test_realtime();
        clear_logs();
        out_ready = 1'b1;
        send_byte(8'h90);
        send_byte(8'h3C);
        send_byte(8'hF8);
`ifndef MIDI_ACTIVE_SENSE_EN
        send_byte(8'hFE);
`endif
        send_byte(8'h64);
        send_byte(8'hC5);
        send_byte(8'hFA);
        send_byte(8'h07);
        wait_cycles(6);
        checks++;
        if (got_q.size() != 2 || exp_q.size() != 2) begin
            errors++; $display("FAIL realtime_count got=%0d required=2", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL realtime_msg%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_sysex();
        clear_logs();
        out_ready = 1'b1;
        send_byte(8'hF0);
        checks++;
        if (sysex_busy !== 1'b1) begin errors++; $display("FAIL sysex_busy_start got=%b required=1", sysex_busy); end
        send_byte(8'h7E);
        send_byte(8'h01);
        send_byte(8'h02);
        checks++;
        if (sysex_busy !== 1'b1) begin errors++; $display("FAIL sysex_busy_mid got=%b required=1", sysex_busy); end
        send_byte(8'hF7);
        checks++;
        if (sysex_busy !== 1'b0) begin errors++; $display("FAIL sysex_busy_end got=%b required=0", sysex_busy); end
        send_byte(8'h3C);
        send_byte(8'h40);
        // Song-position skips two bytes and keeps running status for what follows.
        send_byte(8'hB2);
        send_byte(8'hF2);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h07);
        send_byte(8'h55);
        wait_cycles(6);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL sysex_count got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL sysex_msg%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send_byte(8'h90);
                    send_byte(8'h30 + 8'(i));
                    send_byte(8'h50 + 8'(i));
                end
            end
            begin
                wait_cycles(40);
                checks += 4;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b required=0", in_ready); end
                if (out_valid !== 1'b1) begin errors++; $display("FAIL full_out_valid got=%b required=1", out_valid); end
                if ({out_status, out_data1, out_data2} !== {8'h90, 7'h30, 7'h50}) begin
                    errors++; $display("FAIL full_head got=%h required=%h", {out_status, out_data1, out_data2}, {8'h90, 7'h30, 7'h50});
                end
                if (got_q.size() != 0) begin errors++; $display("FAIL full_no_pop got=%0d required=0", got_q.size()); end
                wait_cycles(5);
                checks++;
                if ({out_status, out_data1, out_data2} !== {8'h90, 7'h30, 7'h50}) begin
                    errors++; $display("FAIL head_stable got=%h required=%h", {out_status, out_data1, out_data2}, {8'h90, 7'h30, 7'h50});
                end
                out_ready = 1'b1;
            end
        join
        wait_cycles(10);
        checks++;
        if (got_q.size() != 5 || exp_q.size() != 5) begin
            errors++; $display("FAIL b2b_count got=%0d required=5", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_msg%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        bit done = 0;
        clear_logs();
        fork
            begin
                for (int n = 0; n < 400; n++) begin
                    logic [7:0] b;
                    int r = $urandom_range(0, 99);
                    if (r < 10)      b = 8'h00;
                    else if (r < 55) b = 8'($urandom_range(0, 127));
                    else if (r < 80) b = 8'($urandom_range(8'h80, 8'hEF));
                    else if (r < 88) b = 8'($urandom_range(8'hF0, 8'hF7));
                    else begin
                        b = 8'($urandom_range(8'hF8, 8'hFF));
                        if (b == 8'hFE) b = 8'hFF;
                    end
                    send_byte(b);
                    if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 3));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_cycles(12);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL random_count got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_msg%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_message();
        clear_logs();
        out_ready = 1'b1;
        send_byte(8'h90);
        send_byte(8'h3C);
        reset_n = 1'b0;
        wait_cycles(2);
        reset_n = 1'b1;
        model_reset();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%b required=0", out_valid); end
        wait_cycles(2);
        send_byte(8'h40);
        send_byte(8'h7F);
        wait_cycles(6);
        checks++;
        if (got_q.size() != 0 || exp_q.size() != 0) begin
            errors++; $display("FAIL midreset_output got=%0d required=0", got_q.size());
        end
    endtask

`ifdef MIDI_ACTIVE_SENSE_EN
    task automatic test_active_sense();
        clear_logs();
        out_ready = 1'b1;
        send_byte(8'hFE);
        wait_cycles(SENSE_MS_TB * CLK_HZ_TB / 1000 + 10);
        exp_q.push_back({8'hFE, 7'h00, 7'h00});
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL sense_count got=%0d required=1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL sense_msg got=%h required=%h", got_q[0], exp_q[0]); end
        end
        wait_cycles(SENSE_MS_TB * CLK_HZ_TB / 1000 + 10);
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL sense_once got=%0d required=1", got_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_running_status();
        test_realtime();
        test_sysex();
        test_back_to_back();
        test_random();
        test_reset_mid_message();
`ifdef MIDI_ACTIVE_SENSE_EN
        test_active_sense();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
